// File: rtl/link_framer_pkg.sv
// Shared constants, FIFO tag codes, link word-type codes and framer state for link_framer.
package link_framer_pkg;

    localparam int FIFO_AW     = 6;
    localparam int DAT_W       = 52;
    localparam int CNT_W       = 8;
    localparam int ENTRY_W     = DAT_W + 2;
    localparam int FIFO_DEPTH  = 1 << FIFO_AW;
    localparam int DATA_LIMIT  = FIFO_DEPTH - 2;
    localparam int DROP_BIT    = 3;

    localparam logic [1:0] TAG_DATA  = 2'b00;
    localparam logic [1:0] TAG_SOE   = 2'b01;
    localparam logic [1:0] TAG_EOE   = 2'b10;
    localparam logic [1:0] TAG_EOSOE = 2'b11;

    localparam logic [1:0] WT_HDR = 2'b10;
    localparam logic [1:0] WT_DAT = 2'b01;
    localparam logic [1:0] WT_TRL = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_TRL} state_e;

    // Marker entries carry the BX in [2:0] and the closing event's drop flag in DROP_BIT.
    function automatic logic [DAT_W-1:0] marker_payload(input logic [2:0] bx, input logic drop);
        logic [DAT_W-1:0] p;
        p           = '0;
        p[2:0]      = bx;
        p[DROP_BIT] = drop;
        return p;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO with a registered head slot; level counts every entry not yet popped,
// including the one already presented on rd_data_o.
module link_fifo
    import link_framer_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int W  = ENTRY_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          rd_valid_o,
    output logic [AW:0]   level_o,
    output logic          full_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q, mem_cnt;
    logic [W-1:0]  rd_data_q;
    logic          rd_valid_q;
    logic          wr_ok, pop, refill;

    assign full_o     = (level_q == (AW+1)'(DEPTH));
    assign wr_ok      = wr_en_i && !full_o;
    assign pop        = rd_en_i && rd_valid_q;
    assign mem_cnt    = level_q - (AW+1)'(rd_valid_q);
    assign refill     = (mem_cnt != '0) && (!rd_valid_q || pop);
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign level_o    = level_q;

    // NOTE: the storage array has no reset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + AW'(1);
            if (refill) begin
                rd_data_q <= mem_q[rptr_q];
                rptr_q    <= rptr_q + AW'(1);
            end
            if (refill)   rd_valid_q <= 1'b1;
            else if (pop) rd_valid_q <= 1'b0;
            level_q <= level_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/link_framer.sv
// Frames the per-BX readout stream into HEADER / DATA / TRAILER 64-bit link words,
// buffered through link_fifo against link backpressure.
module link_framer
    import link_framer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               new_event,
    input  logic [2:0]         BX,
    input  logic [DAT_W-1:0]   mem_dat_stream,
    input  logic               valid,
    input  logic               none,
    output logic [63:0]        link_data,
    output logic               link_valid,
    input  logic               link_ready,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    logic               evt_open_q, evt_drop_q, overflow_q;
    logic               wr_en, drop_now, fifo_full;
    logic [ENTRY_W-1:0] wr_data;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = '0;
        drop_now = 1'b0;
        if (new_event) begin
            wr_en    = 1'b1;
            drop_now = valid && evt_open_q;
            wr_data  = {evt_open_q ? TAG_EOSOE : TAG_SOE, marker_payload(BX, evt_drop_q || drop_now)};
        end else if (none && evt_open_q) begin
            wr_en    = 1'b1;
            drop_now = valid;
            wr_data  = {TAG_EOE, marker_payload(3'b000, evt_drop_q || drop_now)};
        end else if (valid && evt_open_q) begin
            if (fifo_level < (FIFO_AW+1)'(DATA_LIMIT)) begin
                wr_en   = 1'b1;
                wr_data = {TAG_DATA, mem_dat_stream};
            end else begin
                drop_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_open_q <= 1'b0;
            evt_drop_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (drop_now || (wr_en && fifo_full)) overflow_q <= 1'b1;
            if (new_event) begin
                evt_open_q <= 1'b1;
                evt_drop_q <= 1'b0;
            end else if (none && evt_open_q) begin
                evt_open_q <= 1'b0;
                evt_drop_q <= 1'b0;
            end else if (drop_now) begin
                evt_drop_q <= 1'b1;
            end
        end
    end

    logic [ENTRY_W-1:0] head;
    logic               head_valid, out_free, consume;
    logic [1:0]         head_tag;
    logic [DAT_W-1:0]   head_pay;

    state_e             state_q;
    logic [63:0]        link_data_q;
    logic               link_valid_q, reopen_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DAT_W-1:0]   chk_q;
    logic [2:0]         bx_q;

    link_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (consume),
        .rd_data_o  (head),
        .rd_valid_o (head_valid),
        .level_o    (fifo_level),
        .full_o     (fifo_full)
    );

    assign head_tag = head[ENTRY_W-1 -: 2];
    assign head_pay = head[DAT_W-1:0];
    assign out_free = !link_valid_q || link_ready;
    // A combined EOE+SOE entry yields two words; the header half is emitted without a pop.
    assign consume  = out_free && head_valid && !(state_q == ST_TRL && reopen_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
            reopen_q     <= 1'b0;
            cnt_q        <= '0;
            chk_q        <= '0;
            bx_q         <= '0;
        end else if (out_free) begin
            link_valid_q <= 1'b0;
            case (state_q)
                ST_HDR, ST_DATA: begin
                    if (head_valid && head_tag == TAG_DATA) begin
                        link_data_q  <= {WT_DAT, 10'b0, head_pay};
                        link_valid_q <= 1'b1;
                        cnt_q        <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                        chk_q        <= chk_q ^ head_pay;
                        state_q      <= ST_DATA;
                    end else if (head_valid && (head_tag == TAG_EOE || head_tag == TAG_EOSOE)) begin
                        link_data_q  <= {WT_TRL, head_pay[DROP_BIT], 1'b0, chk_q, cnt_q};
                        link_valid_q <= 1'b1;
                        cnt_q        <= '0;
                        chk_q        <= '0;
                        reopen_q     <= (head_tag == TAG_EOSOE);
                        bx_q         <= head_pay[2:0];
                        state_q      <= ST_TRL;
                    end
                end
                default: begin
                    if (state_q == ST_TRL && reopen_q) begin
                        link_data_q  <= {WT_HDR, 59'b0, bx_q};
                        link_valid_q <= 1'b1;
                        reopen_q     <= 1'b0;
                        state_q      <= ST_HDR;
                    end else if (head_valid && head_tag == TAG_SOE) begin
                        link_data_q  <= {WT_HDR, 59'b0, head_pay[2:0]};
                        link_valid_q <= 1'b1;
                        state_q      <= ST_HDR;
                    end else begin
                        state_q      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign link_data  = link_data_q;
    assign link_valid = link_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_link_framer.sv
// Self-checking bench for link_framer: directed vector table, multi-cycle corner sequences
// and random events checked against an event-level model of the framed output stream.
module tb_link_framer;

    logic        clk = 1'b0;
    logic        reset, new_event, valid, none, link_valid, overflow;
    logic        link_ready = 1'b1;
    logic [2:0]  BX;
    logic [51:0] mem_dat_stream;
    logic [63:0] link_data;
    logic [6:0]  fifo_level;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          ready_mode = 0;

    bit          m_open;
    int          m_cnt;
    logic [51:0] m_chk;

    link_framer dut (
        .clk            (clk),
        .reset          (reset),
        .new_event      (new_event),
        .BX             (BX),
        .mem_dat_stream (mem_dat_stream),
        .valid          (valid),
        .none           (none),
        .link_data      (link_data),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .overflow       (overflow),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] w_hdr(logic [2:0] bx);
        return {2'b10, 59'b0, bx};
    endfunction

    function automatic logic [63:0] w_dat(logic [51:0] p);
        return {2'b01, 10'b0, p};
    endfunction

    function automatic logic [63:0] w_trl(logic drop, logic [51:0] chk, logic [7:0] cnt);
        return {2'b11, drop, 1'b0, chk, cnt};
    endfunction

    function automatic logic [51:0] rand52();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[51:0];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Event-level model: the expected link stream follows directly from the event rules.
    task automatic model_step(bit ne, logic [2:0] bx, bit vld, logic [51:0] d, bit nn);
        if (ne) begin
            if (m_open) exp_q.push_back(w_trl(1'b0, m_chk, 8'(m_cnt)));
            exp_q.push_back(w_hdr(bx));
            m_open = 1'b1;
            m_cnt  = 0;
            m_chk  = '0;
        end else if (nn) begin
            if (m_open) exp_q.push_back(w_trl(1'b0, m_chk, 8'(m_cnt)));
            m_open = 1'b0;
        end else if (vld && m_open) begin
            exp_q.push_back(w_dat(d));
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_chk = m_chk ^ d;
        end
    endtask

    task automatic drive(bit ne, logic [2:0] bx, bit vld, logic [51:0] d, bit nn);
        new_event      = ne;
        BX             = bx;
        valid          = vld;
        mem_dat_stream = d;
        none           = nn;
        @(posedge clk);
        #1;
        new_event = 1'b0;
        valid     = 1'b0;
        none      = 1'b0;
    endtask

    task automatic step(bit ne, logic [2:0] bx, bit vld, logic [51:0] d, bit nn);
        model_step(ne, bx, vld, d, nn);
        drive(ne, bx, vld, d, nn);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || link_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending_words", 64'(exp_q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       link_ready = 1'b1;
            1:       link_ready = 1'b0;
            default: link_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [63:0] prev_data;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid_held", 64'(link_valid), 64'd1);
                check("stall_data_held", link_data, prev_data);
            end
            if (link_valid && link_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h, expected no word", link_data);
                end else begin
                    check("link_word", link_data, exp_q.pop_front());
                end
            end
            prev_stall = link_valid && !link_ready;
            prev_data  = link_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        bit          ne;
        logic [2:0]  bx;
        bit          vld;
        logic [51:0] dat;
        bit          nn;
        int          nexp;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    initial begin
        vec_t        tbl[12];
        logic [51:0] a, b, c, d, e, chk;
        logic [63:0] r;
        int          n;

        a = 52'h0123456789ABC;
        b = 52'hFEDCBA9876543;
        c = 52'h5A5A5A5A5A5A5;
        d = 52'h000000000FFFF;
        e = 52'hA000000000001;
        tbl[0]  = '{1'b1, 3'd3, 1'b0, '0, 1'b0, 1, w_hdr(3'd3), '0};
        tbl[1]  = '{1'b0, 3'd0, 1'b1, a,  1'b0, 1, w_dat(a), '0};
        tbl[2]  = '{1'b0, 3'd0, 1'b1, b,  1'b0, 1, w_dat(b), '0};
        tbl[3]  = '{1'b0, 3'd0, 1'b1, c,  1'b0, 1, w_dat(c), '0};
        tbl[4]  = '{1'b0, 3'd0, 1'b0, '0, 1'b1, 1, w_trl(1'b0, a ^ b ^ c, 8'd3), '0};
        tbl[5]  = '{1'b1, 3'd5, 1'b0, '0, 1'b0, 1, w_hdr(3'd5), '0};
        tbl[6]  = '{1'b0, 3'd0, 1'b0, '0, 1'b1, 1, w_trl(1'b0, '0, 8'd0), '0};
        tbl[7]  = '{1'b1, 3'd1, 1'b0, '0, 1'b0, 1, w_hdr(3'd1), '0};
        tbl[8]  = '{1'b0, 3'd0, 1'b1, d,  1'b0, 1, w_dat(d), '0};
        tbl[9]  = '{1'b1, 3'd2, 1'b0, '0, 1'b0, 2, w_trl(1'b0, d, 8'd1), w_hdr(3'd2)};
        tbl[10] = '{1'b0, 3'd0, 1'b1, e,  1'b0, 1, w_dat(e), '0};
        tbl[11] = '{1'b0, 3'd0, 1'b0, '0, 1'b1, 1, w_trl(1'b0, e, 8'd1), '0};

        reset = 1'b1; new_event = 1'b0; valid = 1'b0; none = 1'b0; BX = '0; mem_dat_stream = '0;
        m_open = 1'b0; m_cnt = 0; m_chk = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_link_valid", 64'(link_valid), 64'd0);
        check("reset_link_data", link_data, 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_fifo_level", 64'(fifo_level), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed events: basic framing, empty event, back-to-back close/open.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].nexp > 0) exp_q.push_back(tbl[i].exp0);
            if (tbl[i].nexp > 1) exp_q.push_back(tbl[i].exp1);
            drive(tbl[i].ne, tbl[i].bx, tbl[i].vld, tbl[i].dat, tbl[i].nn);
        end
        wait_drain(200);

        // Two-cycle latency from SOE write to header on the link.
        exp_q.push_back(w_hdr(3'd4));
        exp_q.push_back(w_trl(1'b0, '0, 8'd0));
        new_event = 1'b1; BX = 3'd4;
        @(posedge clk);
        #1;
        new_event = 1'b0; none = 1'b1;
        @(negedge clk);
        check("latency_edge1_valid", 64'(link_valid), 64'd0);
        @(posedge clk);
        #1;
        none = 1'b0;
        @(negedge clk);
        check("latency_edge2_valid", 64'(link_valid), 64'd0);
        @(negedge clk);
        check("latency_edge3_valid", 64'(link_valid), 64'd1);
        check("latency_edge3_hdr", link_data, w_hdr(3'd4));
        @(posedge clk);
        #1;
        wait_drain(100);

        // Long stall: 70 words offered, 62 fit below the reserved entries.
        ready_mode = 1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back(w_hdr(3'd6));
        drive(1'b1, 3'd6, 1'b0, '0, 1'b0);
        chk = '0;
        for (int i = 0; i < 70; i++) begin
            logic [51:0] w;
            w = rand52();
            if (i < 62) begin
                exp_q.push_back(w_dat(w));
                chk = chk ^ w;
            end
            drive(1'b0, 3'd0, 1'b1, w, 1'b0);
        end
        exp_q.push_back(w_trl(1'b1, chk, 8'd62));
        drive(1'b0, 3'd0, 1'b0, '0, 1'b1);
        check("stall_overflow", 64'(overflow), 64'd1);
        check("stall_fifo_level", 64'(fifo_level), 64'd63);
        repeat (8) @(posedge clk);
        #1;
        check("stall_hdr_valid", 64'(link_valid), 64'd1);
        check("stall_hdr_word", link_data, w_hdr(3'd6));
        ready_mode = 0;
        wait_drain(300);
        check("overflow_sticky", 64'(overflow), 64'd1);
        check("drained_level", 64'(fifo_level), 64'd0);

        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("reset_clears_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Random events under random backpressure.
        ready_mode = 2;
        for (int ev = 0; ev < 20; ev++) begin
            n = 0;
            while (fifo_level >= 7'd16 && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("random_room_wait", 64'(fifo_level < 7'd16), 64'd1);
            step(1'b1, 3'($urandom_range(0, 7)), 1'b0, '0, 1'b0);
            for (int i = 0; i < int'($urandom_range(0, 10)); i++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 3'd0, 1'b0, '0, 1'b0);
                step(1'b0, 3'd0, 1'b1, rand52(), 1'b0);
            end
            if (ev == 19 || $urandom_range(0, 2) != 0) begin
                step(1'b0, 3'd0, 1'b0, '0, 1'b1);
                if ($urandom_range(0, 3) == 0) step(1'b0, 3'd0, 1'b1, rand52(), 1'b0);
            end
        end
        wait_drain(3000);
        check("random_no_overflow", 64'(overflow), 64'd0);

        // Reset in the middle of an event, then a clean event.
        ready_mode = 0;
        @(posedge clk);
        #1;
        step(1'b1, 3'd2, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b1, rand52(), 1'b0);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("midreset_link_valid", 64'(link_valid), 64'd0);
        check("midreset_fifo_level", 64'(fifo_level), 64'd0);
        exp_q.delete();
        m_open = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        r = {$urandom(), $urandom()};
        step(1'b1, 3'd7, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b1, r[51:0], 1'b0);
        step(1'b0, 3'd0, 1'b1, ~r[51:0], 1'b0);
        step(1'b0, 3'd0, 1'b0, '0, 1'b1);
        wait_drain(100);
        check("final_fifo_level", 64'(fifo_level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
